sync_counter: RTL and testbench

SYNC_COUNTER -- requirements
Module: sync_counter

---
 rtl/sync_counter.sv | 107 ++++++++++
 tb/tb_sync_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sync_counter.sv
// sync_counter: up/down counter with parallel load and a selectable terminal behaviour
// (wrap, saturate or reload LoadData).
// Optional build macro COUNTER_CARRY_REG_EN: when defined, Carry is a registered one-cycle
// pulse following each terminal count step. When undefined, Carry is a combinational
// decode of the current count and direction.
module sync_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VALUE = 255,
   parameter int unsigned MODE      = 0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             ClockEnable,
   input  logic             Load,
   input  logic             Up,
   input  logic [WIDTH-1:0] LoadData,
   output logic [WIDTH-1:0] CountValue,
   output logic             Carry
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] One    = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             term_up, term_dn, term_any;
   logic             event_step;

   // Terminal decode of the present count; a count above MAX_VALUE (via load) is up-terminal.
   always_comb begin
      term_up  = Up && (count_q >= MaxVal);
      term_dn  = !Up && (count_q == '0);
      term_any = term_up || term_dn;
   end

   // Next-count selection: hold, load, normal step, or the mode-specific terminal action.
   always_comb begin
      count_d    = count_q;
      event_step = 1'b0;
      if (ClockEnable) begin
         if (Load) begin
            count_d = LoadData;
         end else if (term_up) begin
            event_step = 1'b1;
            if (MODE == 0) begin
               count_d = '0;
            end else if (MODE == 1) begin
               count_d = count_q;
            end else begin
               count_d = LoadData;
            end
         end else if (term_dn) begin
            event_step = 1'b1;
            if (MODE == 0) begin
               count_d = MaxVal;
            end else if (MODE == 1) begin
               count_d = '0;
            end else begin
               count_d = LoadData;
            end
         end else if (Up) begin
            count_d = count_q + One;
         end else begin
            count_d = count_q - One;
         end
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign CountValue = count_q;

`ifdef COUNTER_CARRY_REG_EN
   logic carry_q, carry_d;

   // Carry pulse is set only by a count step taken at a terminal count, never by a load.
   always_comb begin
      carry_d = event_step;
   end

   // Carry register, cleared by reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         carry_q <= 1'b0;
      end else begin
         carry_q <= carry_d;
      end
   end

   assign Carry = carry_q;
`else
   logic unused_event;

   // Combinational carry follows the current count/direction, regardless of enable and load.
   always_comb begin
      unused_event = event_step;
      Carry        = term_any;
   end
`endif

endmodule

// File: tb/tb_sync_counter.sv
// Directed self-checking bench for sync_counter: four instances (wrap, saturate, reload,
// and an 8-bit full-range wrap) share one stimulus stream; each phase checks the relevant
// instance(s) against hand-computed values. Carry expectations follow COUNTER_CARRY_REG_EN.
module tb_sync_counter;

   logic       clk;
   logic       rst_n;
   logic       ce;
   logic       load;
   logic       up;
   logic [7:0] ld;

   logic [3:0] cnt0, cnt1, cnt2;
   logic [7:0] cnt3;
   logic       cy0, cy1, cy2, cy3;

   int vectors;
   int miscompares;

   sync_counter #(.WIDTH(4), .MAX_VALUE(9), .MODE(0)) u_wrap (
      .Clock(clk), .Reset(rst_n), .ClockEnable(ce), .Load(load), .Up(up),
      .LoadData(ld[3:0]), .CountValue(cnt0), .Carry(cy0)
   );

   sync_counter #(.WIDTH(4), .MAX_VALUE(9), .MODE(1)) u_sat (
      .Clock(clk), .Reset(rst_n), .ClockEnable(ce), .Load(load), .Up(up),
      .LoadData(ld[3:0]), .CountValue(cnt1), .Carry(cy1)
   );

   sync_counter #(.WIDTH(4), .MAX_VALUE(9), .MODE(2)) u_rel (
      .Clock(clk), .Reset(rst_n), .ClockEnable(ce), .Load(load), .Up(up),
      .LoadData(ld[3:0]), .CountValue(cnt2), .Carry(cy2)
   );

   sync_counter #(.WIDTH(8), .MAX_VALUE(255), .MODE(0)) u_full (
      .Clock(clk), .Reset(rst_n), .ClockEnable(ce), .Load(load), .Up(up),
      .LoadData(ld), .CountValue(cnt3), .Carry(cy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle 1 time unit before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("%s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Carry check picks the expectation matching the carry build option.
   task automatic chkc(input string tag, input logic obs, input logic exp_comb,
                       input logic exp_reg);
      logic exp;
`ifdef COUNTER_CARRY_REG_EN
      exp = exp_reg;
`else
      exp = exp_comb;
`endif
      chk(tag, int'(obs), int'(exp));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b0; ce = 1'b1; load = 1'b0; up = 1'b1; ld = 8'd0;
      #2;

      // Reset state
      step();
      chk("rst_cnt0", int'(cnt0), 0);
      chk("rst_cnt3", int'(cnt3), 0);
      chkc("rst_cy0", cy0, 1'b0, 1'b0);

      // Wrap and saturate counting up from reset
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk($sformatf("wrap_cnt_%0d", k), int'(cnt0), k % 10);
         chkc($sformatf("wrap_cy_%0d", k), cy0, (k % 10) == 9, k == 10);
         chk($sformatf("sat_cnt_%0d", k), int'(cnt1), (k > 9) ? 9 : k);
         chkc($sformatf("sat_cy_%0d", k), cy1, k >= 9, k >= 10);
      end

      // Saturate: down from 0 holds, then up to 9 and hold
      rst_n = 1'b0; up = 1'b0;
      step();
      chkc("sat_rst_dn_cy", cy1, 1'b1, 1'b0);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("sat_dn_cnt_%0d", k), int'(cnt1), 0);
         chkc($sformatf("sat_dn_cy_%0d", k), cy1, 1'b1, 1'b1);
      end
      up = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk($sformatf("sat_up_cnt_%0d", k), int'(cnt1), (k > 9) ? 9 : k);
         chkc($sformatf("sat_up_cy_%0d", k), cy1, k >= 9, k == 10);
      end

      // Reload mode
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; load = 1'b1; ld = 8'd5;
      step();
      chk("rel_load", int'(cnt2), 5);
      chkc("rel_load_cy", cy2, 1'b0, 1'b0);
      load = 1'b0;
      for (int k = 6; k <= 9; k++) begin
         step();
         chk($sformatf("rel_up_%0d", k), int'(cnt2), k);
      end
      chkc("rel_at9_cy", cy2, 1'b1, 1'b0);
      step();
      chk("rel_up_term", int'(cnt2), 5);
      chkc("rel_up_term_cy", cy2, 1'b0, 1'b1);
      rst_n = 1'b0; up = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("rel_dn_term", int'(cnt2), 5);
      chkc("rel_dn_term_cy", cy2, 1'b0, 1'b1);

      // Reset overrides load; disabled edge ignores load
      rst_n = 1'b0; up = 1'b1;
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) step();
      chk("pri_cnt6", int'(cnt0), 6);
      rst_n = 1'b0; load = 1'b1; ld = 8'd3;
      step();
      chk("pri_rst_over_load", int'(cnt0), 0);
      rst_n = 1'b1; ce = 1'b0;
      step();
      chk("pri_ce_over_load", int'(cnt0), 0);
      chkc("pri_ce_cy", cy0, 1'b0, 1'b0);
      ce = 1'b1; load = 1'b0;
      step();
      chk("pri_resume", int'(cnt0), 1);

      // Disabled edge at terminal: count held, registered carry not set
      load = 1'b1; ld = 8'd9;
      step();
      chk("hold_load9", int'(cnt0), 9);
      ce = 1'b0; load = 1'b0;
      step();
      chk("hold_ce0", int'(cnt0), 9);
      chkc("hold_ce0_cy", cy0, 1'b1, 1'b0);
      ce = 1'b1;

      // Load above MAX_VALUE, then up step
      load = 1'b1; ld = 8'd12;
      step();
      chk("over_load_wrap", int'(cnt0), 12);
      chk("over_load_sat", int'(cnt1), 12);
      chkc("over_load_cy", cy0, 1'b1, 1'b0);
      load = 1'b0;
      step();
      chk("over_step_wrap", int'(cnt0), 0);
      chk("over_step_sat", int'(cnt1), 12);
      chkc("over_step_cy_wrap", cy0, 1'b0, 1'b1);
      chkc("over_step_cy_sat", cy1, 1'b1, 1'b1);

      // 8-bit full range wrap in both directions
      rst_n = 1'b0; up = 1'b0;
      step();
      chkc("full_rst_cy", cy3, 1'b1, 1'b0);
      rst_n = 1'b1;
      step();
      chk("full_dn_wrap", int'(cnt3), 255);
      chkc("full_dn_cy", cy3, 1'b0, 1'b1);
      up = 1'b1;
      #1;
      chkc("full_at255_up_cy", cy3, 1'b1, 1'b1);
      step();
      chk("full_up_wrap", int'(cnt3), 0);
      chkc("full_up_cy", cy3, 1'b0, 1'b1);
      step();
      chk("full_up_one", int'(cnt3), 1);
      chkc("full_up_one_cy", cy3, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
